alu_lhs_multishift: RTL and testbench
=====================================

# alu_lhs_multishift

Parametrised, multi-cycle successor to the ALU left-hand-side shift stage. It accepts a WIDTH-bit LHS operand, a mode and a shift count, then shifts or rotates one bit position per AluClock cycle under a Start/Busy/Done handshake. The result and carry are presented registered to the ALU core. It supports counts up to WIDTH plus rotate and arithmetic modes that the single-step 8-bit stage lacks.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of Count

Ports:
- AluClock  in  1  sole clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- LHS  in  WIDTH  operand, sampled only on an accepted Start
- Mode  in  3  operation select, sampled with LHS
- Count  in  CNT_W  shift distance, sampled with LHS
- LCarryIn  in  1  fill bit for SHL/SHR, sampled with LHS
- Start  in  1  request; accepted when Busy=0
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse: Shift/LCarryOut now valid
- Shift  out  WIDTH  registered result
- LCarryOut  out  1  registered carry (last bit shifted out)

## Operation
- Modes:
  - 0 PASS: result=LHS, carry=0.
  - 1 SHL: fill LSB with latched LCarryIn, carry=old MSB.
  - 2 SHR: fill MSB with LCarryIn, carry=old LSB.
  - 3 ZERO: result=0, carry=0.
  - 4 ROL: carry=MSB rotated out.
  - 5 ROR: carry=LSB rotated out.
  - 6 ASR: fill MSB with sign, carry=old LSB.
  - 7: reserved, behaves as PASS.
- Effective count N = min(Count, WIDTH). Result equals N applications of the single-step function; carry is the bit dropped or rotated on the final step.
- Immediate class: PASS, ZERO, 7, or any shift mode with N=0 (result=LHS, carry=0).
- FSM states:
  - IDLE: on Start, latch the operand, fill bit, mode and N.
    - Immediate class: load the result, pulse Done, remain IDLE.
    - Otherwise: load Shift=LHS and LCarryOut=0, set Busy, remaining=N, go to SHIFT.
  - SHIFT: each edge applies one step to Shift and LCarryOut and decrements remaining. On the edge applying the last step, clear Busy, pulse Done and go to IDLE.
- Start while Busy=1 is ignored (not queued). Start in the cycle Done is high is accepted.
- Changes to LHS, Mode, Count or LCarryIn after acceptance have no effect.
- Shift and LCarryOut hold their value between operations. During SHIFT they show intermediate values, which are valid only when Done=1.

## Timing
- Reset (sampled at an edge): Shift=0, LCarryOut=0, Busy=0, Done=0, state=IDLE, counter=0. Reset overrides Start and aborts SHIFT with no Done.
- Start accepted at edge E0:
  - Immediate class: Done=1 and result valid in the cycle after E0; Busy never rises.
  - Shift modes: Busy=1 after E0. Steps occur at E1..EN. After EN, Done=1 and Busy=0. Latency is N cycles from E0 to Done.
- Done is high for exactly one cycle per accepted Start. Busy and Done are never high together.
- Back-to-back: Start held high produces one operation per N+1 cycles (shift) or per cycle (immediate).

## Structure
- Package alu_lhs_pkg holds:
  - the Mode enum (ALU_LHS_PASS, _SHL, _SHR, _ZERO, _ROL, _ROR, _ASR, _RSVD)
  - the FSM state typedef (IDLE, SHIFT)
  - a function is_immediate(mode, n)
- Sub-module alu_lhs_step: combinational, parametrised by WIDTH. Inputs are data, mode and fill bit; outputs are the next data value and the carry. It is shared by the FSM and the bench reference model.
- The top level holds the FSM, the down-counter, the operand/mode/fill latches and the output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset then idle: Shift=0x00, LCarryOut=0, Busy=0, Done=0. Reset asserted mid-SHIFT (ROL, Count=5, after 2 steps) → next cycle all outputs 0, no Done.
- SHL, LHS=0x81, LCarryIn=1, Count=1 → one cycle later Done=1, Shift=0x03, LCarryOut=1. PASS, LHS=0x5A → next cycle Done=1, Shift=0x5A, LCarryOut=0.
- ROR, LHS=0x01, Count=3 → Busy for 3 cycles, then Done with Shift=0x20, LCarryOut=0. ASR, LHS=0x80, Count=3 → Shift=0xF0, LCarryOut=0.
- SHR, LHS=0xA5, LCarryIn=0, Count=9 → clamped to 8; after 8 cycles Shift=0x00, LCarryOut=1. SHL with Count=0 → immediate Done, Shift=LHS, LCarryOut=0.
- ROL, LHS=0x80, Count=4; second Start (ZERO) pulsed while Busy → ignored; final Shift=0x08, LCarryOut=0, exactly one Done. Start held high through Done → next operation is accepted in the Done cycle.
- Randomised operands, modes and counts against the alu_lhs_step reference model: results match and Done count equals accepted Start count.

Source files
------------

// File: rtl/alu_lhs_pkg.sv
// Shared types and helpers for the multi-cycle ALU left-hand-side shifter.
package alu_lhs_pkg;

    // Operation select carried on the Mode input
    typedef enum logic [2:0] {
        ALU_LHS_PASS = 3'd0,
        ALU_LHS_SHL  = 3'd1,
        ALU_LHS_SHR  = 3'd2,
        ALU_LHS_ZERO = 3'd3,
        ALU_LHS_ROL  = 3'd4,
        ALU_LHS_ROR  = 3'd5,
        ALU_LHS_ASR  = 3'd6,
        ALU_LHS_RSVD = 3'd7
    } alu_lhs_mode_e;

    // Sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_lhs_state_e;

    // True when the operation completes in the accept cycle without stepping
    function automatic logic is_immediate(input alu_lhs_mode_e mode, input logic [31:0] n);
        logic imm;
        case (mode)
            ALU_LHS_PASS: imm = 1'b1;
            ALU_LHS_ZERO: imm = 1'b1;
            ALU_LHS_RSVD: imm = 1'b1;
            default:      imm = (n == 32'd0);
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_lhs_step.sv
// Single-position shift/rotate step: next data value and the bit dropped or rotated.
module alu_lhs_step
    import alu_lhs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  alu_lhs_mode_e    i_mode,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

    // Select one step of the requested operation
    always_comb begin
        o_data  = i_data;
        o_carry = 1'b0;
        case (i_mode)
            ALU_LHS_PASS: begin
                o_data  = i_data;
                o_carry = 1'b0;
            end
            ALU_LHS_SHL: begin
                o_data  = {i_data[WIDTH-2:0], i_fill};
                o_carry = i_data[WIDTH-1];
            end
            ALU_LHS_SHR: begin
                o_data  = {i_fill, i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            ALU_LHS_ZERO: begin
                o_data  = {WIDTH{1'b0}};
                o_carry = 1'b0;
            end
            ALU_LHS_ROL: begin
                o_data  = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
                o_carry = i_data[WIDTH-1];
            end
            ALU_LHS_ROR: begin
                o_data  = {i_data[0], i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            ALU_LHS_ASR: begin
                o_data  = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            default: begin
                o_data  = i_data;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_lhs_multishift.sv
// Multi-cycle LHS shifter: one bit position per clock under a Start/Busy/Done handshake.
module alu_lhs_multishift
    import alu_lhs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             AluClock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] LHS,
    input  logic [2:0]       Mode,
    input  logic [CNT_W-1:0] Count,
    input  logic             LCarryIn,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Shift,
    output logic             LCarryOut
);

    alu_lhs_state_e   r_state;
    alu_lhs_mode_e    r_mode;
    logic             r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;

    alu_lhs_mode_e    w_mode;
    logic [CNT_W-1:0] w_n;
    logic             w_imm;
    logic [WIDTH-1:0] w_imm_result;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;

    assign w_mode       = alu_lhs_mode_e'(Mode);
    // Counts beyond WIDTH behave as a full WIDTH-step operation
    assign w_n          = (Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Count;
    assign w_imm        = is_immediate(w_mode, 32'(w_n));
    assign w_imm_result = (w_mode == ALU_LHS_ZERO) ? {WIDTH{1'b0}} : LHS;

    alu_lhs_step #(.WIDTH(WIDTH)) u_step (
        .i_data  (r_shift),
        .i_mode  (r_mode),
        .i_fill  (r_fill),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    // Sequencer, step counter, operand latches and registered outputs
    always_ff @(posedge AluClock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_mode  <= ALU_LHS_PASS;
            r_fill  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_shift <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_mode  <= w_mode;
                        r_fill  <= LCarryIn;
                        r_carry <= 1'b0;
                        if (w_imm) begin
                            r_shift <= w_imm_result;
                            r_done  <= 1'b1;
                        end else begin
                            // Shift register doubles as the operand latch
                            r_shift <= LHS;
                            r_cnt   <= w_n;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_step_data;
                    r_carry <= w_step_carry;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Shift     = r_shift;
    assign LCarryOut = r_carry;

endmodule

// File: tb/tb_alu_lhs_multishift.sv
// Directed and random checks of the multi-cycle LHS shifter at WIDTH=8.
module tb_alu_lhs_multishift;

    logic       AluClock = 1'b0;
    logic       Reset;
    logic [7:0] LHS;
    logic [2:0] Mode;
    logic [3:0] Count;
    logic       LCarryIn;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic [7:0] Shift;
    logic       LCarryOut;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_done = 0;

    typedef struct {
        logic [2:0] md;
        logic [7:0] lhs;
        logic [3:0] cnt;
        logic       fill;
        logic [7:0] es;
        logic       ec;
        int         lat;
    } vec_t;

    vec_t vt[15];

    alu_lhs_multishift #(.WIDTH(8)) dut (
        .AluClock  (AluClock),
        .Reset     (Reset),
        .LHS       (LHS),
        .Mode      (Mode),
        .Count     (Count),
        .LCarryIn  (LCarryIn),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .Shift     (Shift),
        .LCarryOut (LCarryOut)
    );

    always #5 AluClock = ~AluClock;

    task automatic tick();
        @(posedge AluClock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: N single-bit steps of the selected operation
    function automatic void ref_op(input logic [2:0] md, input logic [7:0] lhs, input logic [3:0] cnt,
                                   input logic fill, output logic [7:0] r, output logic c, output int lat);
        int n;
        n = (cnt > 4'd8) ? 8 : int'(cnt);
        r = lhs;
        c = 1'b0;
        if (md == 3'd0 || md == 3'd3 || md == 3'd7 || n == 0) begin
            r   = (md == 3'd3) ? 8'h00 : lhs;
            lat = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                case (md)
                    3'd1: begin c = r[7]; r = {r[6:0], fill}; end
                    3'd2: begin c = r[0]; r = {fill, r[7:1]}; end
                    3'd4: begin c = r[7]; r = {r[6:0], r[7]}; end
                    3'd5: begin c = r[0]; r = {r[0], r[7:1]}; end
                    3'd6: begin c = r[0]; r = {r[7], r[7:1]}; end
                    default: begin end
                endcase
            end
            lat = n;
        end
    endfunction

    // One full operation: pulse Start, scramble inputs, wait for Done and compare
    task automatic run_op(input string nm, input logic [2:0] md, input logic [7:0] lhs, input logic [3:0] cnt,
                          input logic fill, input logic [7:0] es, input logic ec, input int elat);
        int lat;
        int bad_busy;
        Mode = md; LHS = lhs; Count = cnt; LCarryIn = fill; Start = 1'b1;
        tick();
        n_start++;
        Start = 1'b0;
        Mode = 3'($urandom); LHS = 8'($urandom); Count = 4'($urandom); LCarryIn = 1'($urandom);
        lat = 0;
        bad_busy = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy !== 1'b1) bad_busy++;
            tick();
            lat++;
        end
        if (Done === 1'b1) n_done++;
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " busy_during"}, 32'(bad_busy), 32'd0);
        chk({nm, " shift"}, 32'(Shift), 32'(es));
        chk({nm, " carry"}, 32'(LCarryOut), 32'(ec));
        chk({nm, " busy_at_done"}, 32'(Busy), 32'd0);
        tick();
        chk({nm, " done_pulse"}, 32'(Done), 32'd0);
        chk({nm, " hold"}, 32'({Shift, LCarryOut}), 32'({es, ec}));
    endtask

    initial begin
        int dcnt;
        logic [7:0] cap;
        logic [7:0] rr;
        logic rc;
        int rl;
        logic [2:0] md;
        logic [7:0] lhs;
        logic [3:0] cnt;
        logic fill;

        //         mode  lhs    cnt    fill  shift  carry lat
        vt[0]  = '{3'd1, 8'h81, 4'd1,  1'b1, 8'h03, 1'b1, 1};
        vt[1]  = '{3'd0, 8'h5A, 4'd0,  1'b0, 8'h5A, 1'b0, 0};
        vt[2]  = '{3'd5, 8'h01, 4'd3,  1'b0, 8'h20, 1'b0, 3};
        vt[3]  = '{3'd6, 8'h80, 4'd3,  1'b0, 8'hF0, 1'b0, 3};
        vt[4]  = '{3'd2, 8'hA5, 4'd9,  1'b0, 8'h00, 1'b1, 8};
        vt[5]  = '{3'd1, 8'h3C, 4'd0,  1'b1, 8'h3C, 1'b0, 0};
        vt[6]  = '{3'd3, 8'hFF, 4'd5,  1'b1, 8'h00, 1'b0, 0};
        vt[7]  = '{3'd7, 8'h96, 4'd2,  1'b1, 8'h96, 1'b0, 0};
        vt[8]  = '{3'd4, 8'h80, 4'd4,  1'b0, 8'h08, 1'b0, 4};
        vt[9]  = '{3'd2, 8'h01, 4'd1,  1'b1, 8'h80, 1'b1, 1};
        vt[10] = '{3'd4, 8'hC3, 4'd8,  1'b0, 8'hC3, 1'b1, 8};
        vt[11] = '{3'd6, 8'h7F, 4'd15, 1'b1, 8'h00, 1'b0, 8};
        vt[12] = '{3'd5, 8'h02, 4'd1,  1'b1, 8'h01, 1'b0, 1};
        vt[13] = '{3'd1, 8'h40, 4'd2,  1'b0, 8'h00, 1'b1, 2};
        vt[14] = '{3'd0, 8'h00, 4'd7,  1'b1, 8'h00, 1'b0, 0};

        Reset = 1'b1; Start = 1'b0; LHS = 8'h00; Mode = 3'd0; Count = 4'd0; LCarryIn = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk("reset shift", 32'(Shift), 32'd0);
        chk("reset carry", 32'(LCarryOut), 32'd0);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vt[i].md, vt[i].lhs, vt[i].cnt, vt[i].fill, vt[i].es, vt[i].ec, vt[i].lat);

        // Reset in the middle of a ROL by 5, after two steps
        Mode = 3'd4; LHS = 8'h81; Count = 4'd5; LCarryIn = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();
        chk("midreset busy_before", 32'(Busy), 32'd1);
        chk("midreset shift_before", 32'(Shift), 32'h06);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midreset shift", 32'(Shift), 32'd0);
        chk("midreset carry", 32'(LCarryOut), 32'd0);
        chk("midreset busy", 32'(Busy), 32'd0);
        chk("midreset done", 32'(Done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Done === 1'b1) dcnt++;
        end
        chk("midreset no_done", 32'(dcnt), 32'd0);

        // Start pulsed while busy must be ignored
        Mode = 3'd4; LHS = 8'h80; Count = 4'd4; LCarryIn = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Mode = 3'd3; LHS = 8'hFF; Count = 4'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        dcnt = 0;
        cap = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (Done === 1'b1) begin
                dcnt++;
                cap = Shift;
                chk("ignore carry", 32'(LCarryOut), 32'd0);
            end
            tick();
        end
        chk("ignore done_count", 32'(dcnt), 32'd1);
        chk("ignore shift", 32'(cap), 32'h08);
        chk("ignore hold", 32'(Shift), 32'h08);

        // Start held high through Done: next op accepted in the Done cycle
        Mode = 3'd2; LHS = 8'h80; Count = 4'd2; LCarryIn = 1'b0; Start = 1'b1;
        tick();
        Mode = 3'd1; LHS = 8'h11; Count = 4'd1; LCarryIn = 1'b0;
        tick();
        chk("b2b busy", 32'(Busy), 32'd1);
        tick();
        chk("b2b done_a", 32'(Done), 32'd1);
        chk("b2b shift_a", 32'(Shift), 32'h20);
        tick();
        Start = 1'b0;
        chk("b2b busy_b", 32'({Busy, Done}), 32'b10);
        tick();
        chk("b2b done_b", 32'(Done), 32'd1);
        chk("b2b shift_b", 32'(Shift), 32'h22);
        tick();

        // Random operations against the reference function
        n_start = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            md   = 3'($urandom_range(0, 7));
            lhs  = 8'($urandom);
            cnt  = 4'($urandom_range(0, 15));
            fill = 1'($urandom);
            ref_op(md, lhs, cnt, fill, rr, rc, rl);
            run_op($sformatf("rnd%0d m%0d c%0d", i, md, cnt), md, lhs, cnt, fill, rr, rc, rl);
        end
        chk("rnd done_vs_start", 32'(n_done), 32'(n_start));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
